// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: captures each byte the receiver offers, acknowledges it
// with a one-cycle clear pulse, and presents stored bytes first-word fall-through.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_ready,
  input  logic [DW-1:0]            rx_data,
  output logic                     rx_clear,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  input  logic                     overrun_clr,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
  localparam logic [LW-1:0] LevelOne  = LW'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  typedef enum logic [0:0] {
    StIdle,
    StWaitLow
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic capture;
  logic pop;
  logic push;
  logic drop;

  // Capture FSM: take one byte per rx_ready high phase, then wait for the level to drop.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_ready) begin
          capture = rst_n;
          state_d = StWaitLow;
        end
      end
      StWaitLow: begin
        if (!rx_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_clear = capture;

  // A full FIFO can still accept a byte when the head leaves in the same cycle.
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  assign push      = capture & ((level_q < LevelFull) | pop);
  assign drop      = capture & ~push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
  end

  // A drop in the same cycle as a clear wins, so the count restarts at one.
  always_comb begin
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;
    if (overrun_clr) begin
      overrun_d  = 1'b0;
      drop_cnt_d = 8'd0;
    end
    if (drop) begin
      overrun_d  = 1'b1;
      drop_cnt_d = (drop_cnt_d == 8'hFF) ? 8'hFF : drop_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage has no reset; occupancy alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign out_data = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign overrun  = overrun_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter DW, default 8, byte width.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port rx_ready  input  1  receiver byte-available level, held until cleared.
REQ-006 SHALL have port rx_data  input  DW  receiver byte, valid while rx_ready=1.
REQ-007 SHALL have port rx_clear  output  1  one-cycle pulse acknowledging the receiver byte.
REQ-008 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port out_data  output  DW  head byte, first-word fall-through.
REQ-010 SHALL have port out_ready  input  1  consumer pop request, honoured only when out_valid=1.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have port overrun  output  1  sticky flag: byte dropped because FIFO full.
REQ-013 SHALL have port overrun_clr  input  1  clears overrun and drop_cnt.
REQ-014 SHALL have port drop_cnt  output  8  dropped-byte count, saturating at 255.

Function
REQ-015 Capture FSM SHALL have states IDLE and WAIT_LOW.
REQ-016 IDLE with rx_ready=1: SHALL assert rx_clear for that cycle, go to WAIT_LOW, and push rx_data if push is permitted (REQ-019), else drop it.
REQ-017 WAIT_LOW: rx_clear=0, no push; SHALL return to IDLE on the first cycle rx_ready=0; a byte held high indefinitely SHALL be captured exactly once.
REQ-018 rx_clear SHALL never be high for two consecutive cycles.
REQ-019 Push permitted when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
REQ-020 Pop SHALL occur when out_valid=1 and out_ready=1; out_ready with out_valid=0 SHALL be ignored.
REQ-021 out_valid SHALL equal (level!=0); out_data SHALL equal the oldest stored byte, combinationally from storage; out_data is don't-care when out_valid=0.
REQ-022 Pushed byte SHALL appear on out_data/out_valid the cycle after the push (latency 1) when FIFO was empty.
REQ-023 Simultaneous push and pop SHALL leave level unchanged; at level==1 the head advances to the new byte next cycle.
REQ-024 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL be decided by level, not pointer compare.
REQ-025 Byte order SHALL be strictly FIFO across wrap-around.
REQ-026 Drop (REQ-016 not permitted): overrun SHALL set next cycle and drop_cnt SHALL increment, saturating at 255; stored contents unaffected.
REQ-027 overrun_clr=1 SHALL clear overrun and drop_cnt next cycle; a drop in the same cycle SHALL win (overrun=1, drop_cnt=1).
REQ-028 Storage SHALL be a register/distributed array with no reset requirement on contents.

Reset
REQ-029 With rst_n=0 at a clock edge: level=0, pointers=0, FSM=IDLE, rx_clear=0, out_valid=0, overrun=0, drop_cnt=0.
REQ-030 Reset mid-operation SHALL discard all stored bytes; rx_ready held high across reset release SHALL be captured once, in the first cycle after release.
REQ-031 rx_clear SHALL be 0 during every cycle rst_n=0.

Verification
REQ-032 Single byte: rx_ready high 3 cycles with 0x41 -> one rx_clear pulse, out_valid=1 next cycle, out_data=0x41, level=1; pop -> level=0.
REQ-033 Fill/wrap: push 20 bytes 0x00..0x13 with pops interleaved after byte 8 -> output sequence 0x00..0x13 in order, no drops, overrun=0.
REQ-034 Overflow: push 18 bytes, out_ready=0 (DEPTH=16) -> level=16, overrun=1, drop_cnt=2, output bytes 0..15 only; overrun_clr -> overrun=0, drop_cnt=0.
REQ-035 Full with simultaneous pop: level=16, out_ready=1, new byte 0xAA -> no drop, level stays 16, 0xAA is last out.
REQ-036 Reset mid-stream: level=5, assert rst_n=0 one cycle -> level=0, out_valid=0, subsequent byte 0x55 emerges first.
